leds_key_pio: RTL and testbench
===============================

Name: leds_key_pio

Overview:
- Avalon-MM slave input PIO; the read-side counterpart of the LED output PIO.
- Samples external push-buttons/switches and exposes them on the system bus.
- Latches rising edges into an edge-capture register; raises a maskable interrupt to the Nios II.
- Sits on the same system interconnect as the LED PIO, with the same 3-bit word address and 32-bit data bus.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- DEBOUNCE_CYCLES, 50000, stable-cycle count for the debounce filter (used only with LEDS_KEY_DEBOUNCE_EN); minimum 2.
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock, single clock domain.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt, active high.

Behaviour:
- Reset: async assert, sync release to clk. All state is 0: sync FFs, filtered value, debounce counters, edge_capture, irq_mask, previous-value register, readdata, irq.
- Input sync: in_port goes through 2 FF stages; sync_in is the second stage. No logic sits between the two stages.
- Filtered value (filt) equals sync_in when the optional feature is off.
- Edge detect: prev <= filt every cycle. rise[i] = filt[i] & ~prev[i]. Latency from an in_port change to rise is 3 cycles without debounce.
- Register map (wr_strobe = chipselect & ~write_n):
  - addr 0: read = {zero-extend, filt}; writes ignored.
  - addr 2: irq_mask, read/write on bits WIDTH-1:0.
  - addr 3: edge_capture. Read returns the captured bits. A write clears each bit where writedata[i]=1 (write-one-to-clear).
  - Other addresses: read 0, writes ignored.
  - Bits 31:WIDTH always read 0.
- edge_capture[i] is set on rise[i]. Simultaneous rise and W1C on the same bit: set wins, so the bit stays 1.
- readdata is registered every clk from the address mux, regardless of chipselect. Data is valid the cycle after address is presented (read wait 1). A read has no side effects.
- irq <= |(edge_capture & irq_mask), registered, so it asserts 1 cycle after edge_capture sets.
  - Clearing either the mask or the capture bit deasserts irq 1 cycle later.
  - Writing a mask bit while its capture bit is already set asserts irq 1 cycle after the write.
- Reset mid-operation clears pending captures and the mask. There is no spurious edge after reset because prev and filt both restart at 0.
- Fallout: an input held high through reset produces one rise when released. This is intended; software clears edge_capture after init.

Optional Feature:
- Macro: LEDS_KEY_DEBOUNCE_EN.
- Defined:
  - Each bit has a CNT_W counter. When sync_in[i] != filt[i], the counter increments; otherwise it resets to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, filt[i] <= sync_in[i] and the counter resets.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches filt.
  - Added latency is DEBOUNCE_CYCLES cycles.
  - The counter saturates logic-free: it can never exceed DEBOUNCE_CYCLES-1.
- Undefined: no counters; filt = sync_in; CNT_W and DEBOUNCE_CYCLES are unused.

Test Plan:
- Reset then idle; read addr 0, 2, 3 -> readdata = 0x00000000 each, irq = 0.
- No debounce, WIDTH=4: drive in_port 0x0 -> 0x5 -> read addr 0 = 0x5 by cycle 3. Read addr 3 = 0x5, irq stays 0 with mask 0.
- Write addr 2 = 0x4 while edge_capture = 0x5 -> irq = 1 one cycle later. Write addr 3 = 0x4 -> edge_capture = 0x1, irq = 0 next cycle. Write addr 3 = 0x1 -> edge_capture = 0.
- Rising edge on bit 1 in the same cycle as a W1C write of 0x2 to addr 3 -> edge_capture[1] = 1 afterwards.
- LEDS_KEY_DEBOUNCE_EN, DEBOUNCE_CYCLES=8:
  - bit 0 pulse of 5 cycles -> filt and edge_capture unchanged.
  - bit 0 held high for 20 cycles -> filt[0] = 1 exactly 8 cycles after sync_in[0] rises; edge_capture = 0x1.
- Set edge_capture = 0xF and mask = 0xF, then pulse reset_n low for 1 cycle -> readdata, irq, mask and capture are all 0 immediately; registers read 0 after release.

Source files
------------

// File: rtl/leds_key_pio.sv
// leds_key_pio: Avalon-MM input PIO for push-buttons/switches.
// Each input bit runs through its own lane (synchroniser, optional debounce,
// rising-edge detect, edge-capture bit, interrupt-mask bit). The top level
// holds the address decode, the registered read mux and the registered irq.
//
// Register map (word address):
//   0 : filtered input value (read only)
//   2 : irq_mask (read/write)
//   3 : edge_capture (read, write-one-to-clear)
//   others read 0; bits 31:WIDTH always read 0.
//
// Build option: define LEDS_KEY_DEBOUNCE_EN to add a per-bit debounce filter
// of DEBOUNCE_CYCLES stable cycles. Without it, filt is the synchronised input.

module leds_key_pio_lane
`ifdef LEDS_KEY_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
)
`endif
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,       // raw asynchronous input bit
  input  logic ec_clr_i,   // W1C strobe for this capture bit
  input  logic mask_we_i,  // mask register write strobe
  input  logic mask_wd_i,  // mask write data for this bit
  output logic filt_o,
  output logic ec_o,
  output logic mask_o
);

  logic s1_q, sync_q;
  logic filt;
  logic prev_q;
  logic ec_q, ec_d;
  logic mask_q, mask_d;
  logic rise;

  // Two-flop synchroniser, nothing between the stages
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      s1_q   <= in_i;
      sync_q <= s1_q;
    end
  end

`ifdef LEDS_KEY_DEBOUNCE_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;

  // Count consecutive cycles the input disagrees with filt; adopt it after
  // DEBOUNCE_CYCLES. The counter wraps to 0 on adoption, so it never passes
  // DEBOUNCE_CYCLES-1.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_q != filt_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync_q;
`endif

  assign rise = filt & ~prev_q;

  // A new rise beats a same-cycle W1C so no edge is ever lost
  always_comb begin
    ec_d   = rise | (ec_q & ~ec_clr_i);
    mask_d = mask_we_i ? mask_wd_i : mask_q;
  end

  // Edge-detect history, capture and mask bits
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
      ec_q   <= 1'b0;
      mask_q <= 1'b0;
    end else begin
      prev_q <= filt;
      ec_q   <= ec_d;
      mask_q <= mask_d;
    end
  end

  assign filt_o = filt;
  assign ec_o   = ec_q;
  assign mask_o = mask_q;

endmodule

module leds_key_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;

  // Reject configurations the lanes cannot implement
  if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 2 ||
      (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cfg
    $error("leds_key_pio: illegal WIDTH/DEBOUNCE_CYCLES/CNT_W combination");
  end

  logic             wr_strobe;
  logic             mask_we;
  logic [WIDTH-1:0] ec_clr;
  logic [WIDTH-1:0] filt, ec, mask;
  logic [31:0]      rd_q, rd_d;
  logic             irq_q, irq_d;
  logic             unused_wd;

  assign wr_strobe = chipselect & ~write_n;
  assign mask_we   = wr_strobe && (address == ADDR_MASK);
  assign ec_clr    = (wr_strobe && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;
  assign unused_wd = ^(writedata >> WIDTH);

  leds_key_pio_lane
`ifdef LEDS_KEY_DEBOUNCE_EN
    #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W))
`endif
    u_lane [WIDTH-1:0] (
      .clk_i     (clk),
      .rst_ni    (reset_n),
      .in_i      (in_port),
      .ec_clr_i  (ec_clr),
      .mask_we_i (mask_we),
      .mask_wd_i (writedata[WIDTH-1:0]),
      .filt_o    (filt),
      .ec_o      (ec),
      .mask_o    (mask)
    );

  // Read mux and interrupt term; reads have no side effects
  always_comb begin
    rd_d = '0;
    case (address)
      ADDR_DATA: rd_d = 32'(filt);
      ADDR_MASK: rd_d = 32'(mask);
      ADDR_EDGE: rd_d = 32'(ec);
      default:   rd_d = '0;
    endcase
    irq_d = |(ec & mask);
  end

  // readdata is refreshed every cycle regardless of chipselect (read wait 1)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      irq_q <= irq_d;
    end
  end

  assign readdata = rd_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_leds_key_pio.sv
module tb_leds_key_pio;

  localparam int W = 4;
  localparam int D = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = 3'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = 32'd0;
  logic [W-1:0]  in_port = '0;
  logic [31:0]   readdata;
  logic          irq;

  int errs = 0;
  int checks = 0;

  // Reference model state, as seen just after each rising edge
  logic [W-1:0] last_in, m_sync, m_filt, m_prev, m_ec, m_mask;
  logic [31:0]  m_rd;
  logic         m_irq;
  int           run [W];

  leds_key_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_in = '0; m_sync = '0; m_filt = '0; m_prev = '0;
    m_ec = '0; m_mask = '0; m_rd = '0; m_irq = 1'b0;
    for (int i = 0; i < W; i++) run[i] = 0;
  endtask

  // One clock: predict the post-edge state from the pre-edge inputs, then
  // compare readdata/irq at the following falling edge.
  task automatic step();
    logic         wr;
    logic [W-1:0] wdw, n_filt, n_ec, n_mask;
    logic [31:0]  n_rd;
    logic         n_irq;
    int           n_run [W];
    wr  = chipselect && !write_n;
    wdw = writedata[W-1:0];
    case (address)
      3'd0:    n_rd = 32'(m_filt);
      3'd2:    n_rd = 32'(m_mask);
      3'd3:    n_rd = 32'(m_ec);
      default: n_rd = 32'd0;
    endcase
    n_irq  = |(m_ec & m_mask);
    n_ec   = (m_ec & ~((wr && address == 3'd3) ? wdw : '0)) | (m_filt & ~m_prev);
    n_mask = (wr && address == 3'd2) ? wdw : m_mask;
`ifdef LEDS_KEY_DEBOUNCE_EN
    // filt follows the input once it has disagreed for D consecutive cycles
    n_filt = m_filt;
    for (int i = 0; i < W; i++) begin
      n_run[i] = 0;
      if (m_sync[i] != m_filt[i]) begin
        n_run[i] = run[i] + 1;
        if (n_run[i] == D) begin
          n_filt[i] = m_sync[i];
          n_run[i]  = 0;
        end
      end
    end
`else
    n_filt = last_in;
    for (int i = 0; i < W; i++) n_run[i] = 0;
`endif
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      m_prev = m_filt;
      m_sync = last_in;
      last_in = in_port;
      m_filt = n_filt;
      m_ec = n_ec;
      m_mask = n_mask;
      m_rd = n_rd;
      m_irq = n_irq;
      for (int i = 0; i < W; i++) run[i] = n_run[i];
    end
    @(negedge clk);
    chk("rd", readdata, m_rd);
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    model_reset();
    // Reset and idle reads
    repeat (3) step();
    chk("rst_rd", readdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    address = 3'd0; step(); chk("idle_rd0", readdata, 32'd0);
    address = 3'd2; step(); chk("idle_rd2", readdata, 32'd0);
    address = 3'd3; step(); chk("idle_rd3", readdata, 32'd0);
    chk("idle_irq", {31'd0, irq}, 32'd0);

`ifndef LEDS_KEY_DEBOUNCE_EN
    // Input latency and edge capture
    in_port = 4'h5; address = 3'd0;
    step(); step();
    chk("filt_lat2", readdata, 32'd0);
    step();
    chk("filt_lat3", readdata, 32'h5);
    address = 3'd3; step();
    chk("ec_rise", readdata, 32'h5);
    chk("irq_masked", {31'd0, irq}, 32'd0);
    // Mask on an already-captured bit, then partial and full W1C
    bus_wr(3'd2, 32'h4);
    address = 3'd3; step();
    chk("irq_mask_on", {31'd0, irq}, 32'd1);
    bus_wr(3'd3, 32'h4);
    address = 3'd3; step();
    chk("w1c_partial", readdata, 32'h1);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    bus_wr(3'd3, 32'h1);
    address = 3'd3; step();
    chk("w1c_all", readdata, 32'h0);
    // Rise on bit 1 coincides with W1C of bit 1: set wins
    in_port = 4'h7;
    step(); step();
    bus_wr(3'd3, 32'h2);
    address = 3'd3; step();
    chk("set_wins", readdata, 32'h2);
    bus_wr(3'd3, 32'hF);
    bus_wr(3'd2, 32'h0);
`else
    // Short glitch is filtered out
    address = 3'd0;
    in_port = 4'h1; repeat (5) step();
    in_port = 4'h0; repeat (15) step();
    chk("glitch_filt", readdata, 32'h0);
    address = 3'd3; step();
    chk("glitch_ec", readdata, 32'h0);
    // Held input appears exactly D cycles after the synchroniser
    address = 3'd0;
    in_port = 4'h1;
    repeat (10) step();
    chk("deb_early", readdata, 32'h0);
    step();
    chk("deb_on", readdata, 32'h1);
    repeat (9) step();
    address = 3'd3; step();
    chk("deb_ec", readdata, 32'h1);
    bus_wr(3'd3, 32'hF);
`endif

    // Randomised bus traffic and input activity
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
      address    = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(2, 3)) : 3'($urandom_range(0, 7));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 2) != 0);
      writedata  = $urandom;
      step();
    end
    chipselect = 1'b0; write_n = 1'b1;

    // Mid-operation reset with everything captured and enabled
    in_port = 4'h0; repeat (30) step();
    in_port = 4'hF; repeat (30) step();
    bus_wr(3'd2, 32'hF);
    address = 3'd3; step(); step();
    chk("pre_rst_ec", readdata, 32'hF);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async_rd", readdata, 32'd0);
    chk("rst_async_irq", {31'd0, irq}, 32'd0);
    step();
    reset_n = 1'b1;
    address = 3'd2; step();
    chk("post_rst_mask", readdata, 32'd0);
    address = 3'd3; step();
    chk("post_rst_ec", readdata, 32'd0);
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
